// File: rtl/bpsk_rx_framer.sv
// bpsk_rx_framer: receive-side framer behind the BPSK demodulator.
// Hunts for the sync word (either polarity), reads a length byte, then
// collects payload bytes into a small first-word-fall-through FIFO.
//
// Output handshake: a byte transfers on a rising clock edge where
// byte_valid && byte_ready. byte_valid never depends on byte_ready, and
// byte_data stays stable while byte_valid is high and not yet accepted.
module bpsk_rx_framer #(
    parameter logic [15:0] SYNC_WORD      = 16'hD391,
    parameter int          MAX_LEN        = 64,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_toggle,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_start,
    output logic       frame_end,
    output logic [7:0] frame_len,
    output logic       inverted,
    output logic       len_error,
    output logic       overflow,
    output logic       in_frame,
    output logic [1:0] dbg_state
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  MAX_LEN_B = MAX_LEN[7:0];

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_toggle_q;
    logic [15:0]   r_sync;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift8;
    logic [7:0]    r_bytecnt;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_frame_len;
    logic          r_inverted;
    logic          r_frame_start;
    logic          r_frame_end;
    logic          r_len_error;
    logic          r_overflow;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [7:0]    r_hold;

    logic          w_sym;
    logic [15:0]   w_cand;
    logic          w_eff;
    logic [7:0]    w_byte;
    logic          w_last_bit;
    logic          w_timeout;
    logic          w_match;
    logic          w_match_inv;
    logic          w_len_ok;
    logic          w_len_bad;
    logic          w_push;
    logic          w_last_byte;
    logic          w_timeout_hit;
    logic          w_pop;
    logic          w_full;
    logic          w_push_ok;
    logic [7:0]    w_head;

    // Every level change of the demodulator strobe is one symbol.
    assign w_sym      = bit_toggle ^ r_toggle_q;
    assign w_cand     = {r_sync[14:0], bit_in};
    assign w_eff      = bit_in ^ r_inverted;
    assign w_byte     = {r_shift8[6:0], w_eff};
    assign w_last_bit = w_sym && (r_bitcnt == 3'd7);
    assign w_timeout  = !w_sym && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_HUNT;
        else       r_state <= w_state_nxt;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_match       = 1'b0;
        w_match_inv   = 1'b0;
        w_len_ok      = 1'b0;
        w_len_bad     = 1'b0;
        w_push        = 1'b0;
        w_last_byte   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (w_sym && (w_cand == SYNC_WORD)) begin
                    w_match     = 1'b1;
                    w_state_nxt = S_LEN;
                end else if (w_sym && (w_cand == ~SYNC_WORD)) begin
                    w_match     = 1'b1;
                    w_match_inv = 1'b1;
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_last_bit) begin
                    if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
                        w_len_bad   = 1'b1;
                        w_state_nxt = S_HUNT;
                    end else begin
                        w_len_ok    = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (w_last_bit) begin
                    w_push = 1'b1;
                    if ((r_bytecnt + 8'd1) == r_frame_len) begin
                        w_last_byte = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end else if (w_timeout) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_HUNT;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    // Framing datapath: sync shifter, bit/byte counters, timeout and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_toggle_q    <= 1'b0;
            r_sync        <= '0;
            r_bitcnt      <= '0;
            r_shift8      <= '0;
            r_bytecnt     <= '0;
            r_tcnt        <= '0;
            r_frame_len   <= '0;
            r_inverted    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_len_error   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_toggle_q    <= bit_toggle;
            r_frame_start <= w_match;
            r_frame_end   <= w_last_byte;
            r_len_error   <= w_len_bad;

            if (r_state == S_HUNT && w_sym)
                r_sync <= w_cand;
            else if (w_len_bad || w_last_byte || w_timeout_hit)
                r_sync <= '0;

            if (w_match) begin
                r_inverted <= w_match_inv;
                r_bitcnt   <= '0;
            end else if (r_state != S_HUNT && w_sym) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift8 <= w_byte;
            end

            if (w_len_ok || w_len_bad)
                r_frame_len <= w_byte;

            if (w_len_ok)
                r_bytecnt <= '0;
            else if (w_push)
                r_bytecnt <= r_bytecnt + 8'd1;

            if (r_state == S_HUNT || w_sym || w_timeout)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TW'(1);

            // Dropped bytes still count toward the frame length.
            if (w_match)
                r_overflow <= 1'b0;
            else if (w_push && !w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so push-on-full
    // succeeds when the sink is taking the head byte.
    assign w_pop     = (r_count != '0) && byte_ready;
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = (r_count != '0) ? r_mem[r_rd] : r_hold;

    // FIFO storage; contents only matter while occupancy covers the slot.
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr] <= w_byte;
    end

    // FIFO pointers, occupancy, and the held output byte while empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop)     r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
            r_hold  <= w_head;
        end
    end

    assign byte_data   = w_head;
    assign byte_valid  = (r_count != '0);
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_len   = r_frame_len;
    assign inverted    = r_inverted;
    assign len_error   = r_len_error;
    assign overflow    = r_overflow;
    assign in_frame    = (r_state == S_LEN) || (r_state == S_PAYLOAD);
    assign dbg_state   = r_state;

endmodule

// File: doc/bpsk_rx_framer.md
Name: bpsk_rx_framer

Overview:
- Receive-side controller downstream of the BPSK demodulator.
- Consumes the demodulator's per-symbol decision (`guess`) and its toggle-style ready strobe (`write`), then sequences reception: hunt for sync word, read length byte, collect payload bytes.
- Resolves BPSK 180° phase ambiguity by also matching the inverted sync word.
- Delivers payload bytes through a small FIFO with valid/ready handshake to the byte sink.

Parameters:
- SYNC_WORD, 16'hD391, frame sync pattern, MSB received first.
- MAX_LEN, 64, largest legal payload length in bytes (1..255).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
- TIMEOUT_CYCLES, 4096, clock cycles without a symbol event before an in-frame abort.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_in  input  1  demodulator symbol decision (`guess`).
- bit_toggle  input  1  demodulator ready strobe (`write`); every level change marks one new symbol.
- byte_data  output  8  FIFO head byte.
- byte_valid  output  1  FIFO non-empty.
- byte_ready  input  1  sink accepts `byte_data` when high together with `byte_valid`.
- frame_start  output  1  one-cycle pulse on sync match.
- frame_end  output  1  one-cycle pulse when the last payload byte is collected.
- frame_len  output  8  length byte of the current/last frame.
- inverted  output  1  current frame locked on inverted sync; payload bits are inverted back.
- len_error  output  1  one-cycle pulse on illegal length.
- overflow  output  1  sticky: byte dropped because FIFO was full; cleared by `frame_start`.
- in_frame  output  1  state is LEN or PAYLOAD.

Behaviour:
- Reset (async, immediate):
  - all outputs 0; state HUNT; shift register 0; FIFO empty.
  - `toggle_q` = 0, so the first symbol after reset requires `bit_toggle` to go high.
  - A reset mid-frame discards the partial frame and FIFO contents.
- Symbol event:
  - `sym` = (`bit_toggle` != `toggle_q`); `toggle_q` <= `bit_toggle` every cycle.
  - `bit_in` is sampled in the same cycle `sym` is high.
  - Effective bit = `bit_in` XOR `inverted` (in HUNT, `inverted` is not applied).
- HUNT:
  - On `sym`, shift the raw bit into a 16-bit register, LSB end.
  - Candidate word = shifted value including the current bit.
  - Candidate == SYNC_WORD -> LEN, `inverted` <= 0.
  - Candidate == ~SYNC_WORD -> LEN, `inverted` <= 1.
  - On either match: `frame_start` pulses next cycle, bit counter cleared, `overflow` cleared.
- LEN:
  - Collect 8 effective bits, MSB first.
  - On the 8th bit, `frame_len` <= value.
  - Value 0 or > MAX_LEN -> `len_error` pulse, go to HUNT, sync register cleared.
  - Otherwise -> PAYLOAD, byte counter = 0.
- PAYLOAD:
  - Collect 8 bits per byte, MSB first; on the 8th bit push the byte.
  - If the FIFO is full, drop the byte and set `overflow`.
  - On byte number `frame_len`: `frame_end` pulses next cycle, go to HUNT, sync register cleared.
  - The counter advances even on a dropped byte.
- Timeout:
  - A cycle counter resets on each `sym` and in HUNT.
  - Reaching TIMEOUT_CYCLES in LEN/PAYLOAD -> HUNT.
  - No `frame_end`; already-queued bytes are kept.
- FIFO:
  - First-word-fall-through.
  - A push on edge k makes `byte_valid` high in cycle k+1 if the FIFO was empty (1-cycle latency).
  - Pop when `byte_valid && byte_ready`.
  - Simultaneous push and pop while full: the push succeeds and there is no overflow.
  - Simultaneous push and pop while empty: no pop, push succeeds.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - `byte_data` holds its value while `byte_valid` is low.
- Unused symbols in HUNT never reach the FIFO. `bit_in` changes without a toggle are ignored.

Test Plan:
- Reset, then a normal frame: toggle in bits 16'hD391, len 8'h03, bytes 8'h12, 8'h34, 8'h56, with `byte_ready`=1.
  - Expect `frame_start` once, `frame_len`=3, `inverted`=0.
  - Expect bytes 12,34,56 each valid one cycle after their 8th bit, and `frame_end` once after 56.
- Inverted frame: bits 16'h2C6E, then ~8'h02, ~8'hA0, ~8'h0F.
  - Expect `inverted`=1, `frame_len`=2, bytes A0,0F out.
- Bad length: sync followed by len 8'h00, and separately len 8'd65.
  - Expect a `len_error` pulse each time, no bytes, back in HUNT (`in_frame`=0).
  - A following valid frame is received correctly.
- Backpressure: `byte_ready`=0, frame with len 6 bytes 01..06.
  - Expect FIFO holds 01..04, `overflow`=1, 05/06 dropped, `frame_end` still pulses.
  - Raising `byte_ready` drains 01..04 in order.
- Timeout and reset: sync + len 4 + 12 bits, then no toggles for 4096 cycles.
  - Expect `in_frame`=0 with no `frame_end`.
  - Repeat and assert `reset` mid-PAYLOAD: all outputs 0 immediately, FIFO empty.
- Near-miss sync: bit stream containing 16'hD390 and 16'hD391 offset by 1 bit inside noise.
  - Exactly one `frame_start`, aligned to the true pattern.
